instr_prefetch: RTL and testbench

- Byte-stream instruction source feeding the frontend's macro-op port (`instr` / `instr_valid` / `instr_ready`).
- Issues sequential byte reads to the memory port and buffers returned opcode/operand bytes in a small in-order queue.
- Presents the queued bytes one per cycle under valid/ready.
- A `redirect` input restarts fetch at a new PC, flushes the queue and discards responses still in flight.

---
 rtl/instr_prefetch_pkg.sv | 15 +
 rtl/instr_prefetch_byte_fifo.sv | 54 +++++
 rtl/instr_prefetch.sv | 134 +++++++++++++
 tb/tb_instr_prefetch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
package instr_prefetch_pkg;

    localparam int unsigned ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_VEC_LO = 16'hFFFC;
    localparam logic [ADDR_W-1:0] RESET_VEC_HI = 16'hFFFD;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_prefetch_byte_fifo.sv
// In-order byte queue; pointers carry one extra wrap bit to tell full from empty.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full queue is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PW'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Byte-stream instruction prefetcher with credit-limited reads and redirect flush.
// Optional reset-vector fetch is enabled by defining INSTR_PREFETCH_RESET_VECTOR_EN.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 8,
    parameter int unsigned       MAX_OUT  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

`ifdef INSTR_PREFETCH_RESET_VECTOR_EN
    localparam fetch_state_t RESET_STATE = VEC_LO;
`else
    localparam fetch_state_t RESET_STATE = RUN;
`endif

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] req_pc;
    logic [OW-1:0]     out_cnt;
    logic [OW-1:0]     out_next;
    logic [OW-1:0]     discard_cnt;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              run;
    logic              issue;
    logic              push;
    logic              pop;
    logic              flush;

    assign run         = (state == RUN);
    assign flush       = run && redirect;
    assign instr_valid = run && !redirect && !empty;
    assign pop         = instr_valid && instr_ready;
    assign issue       = mem_req && mem_gnt;
    assign push        = run && !redirect && mem_rvalid && (discard_cnt == '0);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pop),
        .flush     (flush),
        .head      (instr),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // rst gates the request so it drops the moment reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = req_pc;
        state_next = state;
        case (state)
            RUN: mem_req = rst && !redirect
                           && (32'(count) + 32'(out_cnt) < 32'(DEPTH))
                           && (32'(out_cnt) < 32'(MAX_OUT));
`ifdef INSTR_PREFETCH_RESET_VECTOR_EN
            VEC_LO: begin
                mem_req  = rst && (out_cnt == '0);
                mem_addr = RESET_VEC_LO;
                if (mem_rvalid) state_next = VEC_HI;
            end
            VEC_HI: begin
                mem_req  = rst && (out_cnt == '0);
                mem_addr = RESET_VEC_HI;
                if (mem_rvalid) state_next = RUN;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        out_next = out_cnt;
        if (issue && !mem_rvalid) begin
            out_next = out_cnt + 1'b1;
        end else if (!issue && mem_rvalid && (out_cnt != '0)) begin
            out_next = out_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RESET_STATE;
            req_pc      <= RESET_PC;
            fetch_pc    <= RESET_PC;
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            state   <= state_next;
            out_cnt <= out_next;
            if (flush) begin
                req_pc      <= redirect_pc;
                fetch_pc    <= redirect_pc;
                discard_cnt <= out_next;
            end else begin
                if (issue && run) req_pc <= req_pc + 1'b1;
                if (pop) fetch_pc <= fetch_pc + 1'b1;
                if (mem_rvalid && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
`ifdef INSTR_PREFETCH_RESET_VECTOR_EN
                if (mem_rvalid && (state == VEC_LO)) req_pc[7:0] <= mem_rdata;
                if (mem_rvalid && (state == VEC_HI)) begin
                    req_pc   <= {mem_rdata, req_pc[7:0]};
                    fetch_pc <= {mem_rdata, req_pc[7:0]};
                end
`endif
            end
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch with a latency-configurable in-order memory model.
`timescale 1ns/1ps
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] fetch_pc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    instr_prefetch #(.DEPTH(8), .MAX_OUT(4), .RESET_PC(16'h0200)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_pc    (fetch_pc)
    );

    typedef struct { logic [15:0] addr; logic [7:0] data; } exp_t;
    typedef struct { int unsigned due; logic [7:0] data; } resp_t;

    exp_t        sb[$];
    resp_t       resp_q[$];
    logic [15:0] issued_addrs[$];
    int unsigned lat = 1;
    int unsigned cyc = 0;
    int unsigned issued_cnt = 0;
    bit          gnt_rand = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'hFFFC) return 8'h34;
        if (a == 16'hFFFD) return 8'h12;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    task automatic expect_from(input logic [15:0] start, input int n);
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{a, mem_byte(a)});
            a = a + 16'd1;
        end
    endtask

    // Memory: accepted requests are answered lat cycles later, in order; reset drops them.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_q.delete();
            issued_addrs.delete();
            issued_cnt = 0;
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b1;
        end else begin
            cyc++;
            if (mem_req && mem_gnt) begin
                resp_q.push_back('{cyc + lat, mem_byte(mem_addr)});
                issued_addrs.push_back(mem_addr);
                issued_cnt++;
            end
            #1;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc + 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = resp_q[0].data;
                void'(resp_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 8'($urandom);
            end
            mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_reset(input int unsigned l);
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        lat = l;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (fetch_pc !== 16'h0200) begin n_bad++; $display("FAIL reset_fetch_pc: got %h want 0200", fetch_pc); end
        n_cmp++; if (mem_addr !== 16'h0200) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0200", mem_addr); end
        n_cmp++; if (instr !== 8'h00) begin n_bad++; $display("FAIL reset_instr: got %h want 00", instr); end
    endtask

    task automatic test_stream();
        exp_t e;
        int first_c, last_c;
        first_c = -1; last_c = -1;
        do_reset(1);
        instr_ready = 1'b1;
        expect_from(16'h0200, 20);
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                if (first_c < 0) first_c = c;
                last_c = c;
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL stream: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stream_left: got %0d want 0", sb.size()); end
        n_cmp++; if (last_c - first_c != 19) begin n_bad++; $display("FAIL stream_rate: got %0d cycles want 19", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset(1);
        expect_from(16'h0200, 16);
        repeat (20) @(negedge clk);
        n_cmp++; if (issued_cnt != 8) begin n_bad++; $display("FAIL bp_issued: got %0d want 8", issued_cnt); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", instr_valid); end
        n_cmp++; if (instr !== mem_byte(16'h0200) || fetch_pc !== 16'h0200) begin
            n_bad++; $display("FAIL bp_head: instr=%h pc=%h want instr=%h pc=0200", instr, fetch_pc, mem_byte(16'h0200));
        end
        instr_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL bp_drain: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL bp_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_redirect_inflight();
        exp_t e;
        do_reset(4);
        for (int c = 0; c < 20 && resp_q.size() != 3; c++) @(negedge clk);
        n_cmp++; if (resp_q.size() != 3) begin n_bad++; $display("FAIL rd_inflight: got %0d want 3", resp_q.size()); end
        redirect = 1'b1; redirect_pc = 16'h8000;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_cycle: req=%b valid=%b want 0 0", mem_req, instr_valid);
        end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h8000) begin
            n_bad++; $display("FAIL rd_restart: req=%b addr=%h want 1 8000", mem_req, mem_addr);
        end
        expect_from(16'h8000, 8);
        instr_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL rd_drain: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rd_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset(4);
        for (int c = 0; c < 20 && resp_q.size() != 3; c++) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h8000;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h4000;
        @(negedge clk);
        redirect = 1'b0;
        expect_from(16'h4000, 8);
        instr_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL b2b_drain: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset(2);
        gnt_rand = 1'b1;
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        expect_from(16'hFFFE, 7);
        instr_ready = 1'b1;
        for (int c = 0; c < 300 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL wrap_drain: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        gnt_rand = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL wrap_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset(4);
        for (int c = 0; c < 20 && resp_q.size() != 2; c++) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h3000;
        #1;
        redirect = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL ar_outputs: req=%b valid=%b want 0 0", mem_req, instr_valid);
        end
        n_cmp++; if (fetch_pc !== 16'h0200 || mem_addr !== 16'h0200) begin
            n_bad++; $display("FAIL ar_pc: pc=%h addr=%h want 0200 0200", fetch_pc, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (issued_cnt != 4) begin n_bad++; $display("FAIL ar_credit: got %0d issued want 4", issued_cnt); end
        expect_from(16'h0200, 8);
        instr_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL ar_drain: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL ar_left: got %0d want 0", sb.size()); end
    endtask

`ifdef INSTR_PREFETCH_RESET_VECTOR_EN
    task automatic test_reset_vector();
        exp_t e;
        do_reset(2);
        instr_ready = 1'b1;
        expect_from(16'h1234, 8);
        for (int c = 0; c < 20 && mem_addr !== 16'hFFFD; c++) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h8000;
        @(negedge clk);
        redirect = 1'b0;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (instr !== e.data || fetch_pc !== e.addr) begin
                    n_bad++;
                    $display("FAIL vec_drain: instr=%h pc=%h want instr=%h pc=%h", instr, fetch_pc, e.data, e.addr);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL vec_left: got %0d want 0", sb.size()); end
        n_cmp++; if (issued_addrs.size() < 2 || issued_addrs[0] !== 16'hFFFC || issued_addrs[1] !== 16'hFFFD) begin
            n_bad++; $display("FAIL vec_reads: first two reads wrong, count %0d want FFFC FFFD", issued_addrs.size());
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef INSTR_PREFETCH_RESET_VECTOR_EN
        test_reset_vector();
`else
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_back_to_back();
        test_wrap();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
